// File: rtl/alu_pkg.sv
// Shared ALU package: 4-bit op code encoding and arbiter FSM states.
package alu_pkg;

   localparam int SHAMT_W = 5;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SLT  = 4'b0101,
      OP_SLTU = 4'b0110,
      OP_SLL  = 4'b0111,
      OP_SRL  = 4'b1000,
      OP_SRA  = 4'b1001
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   // Shift ops take their amount from the low bits of b only.
   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU. Unknown op codes yield zero.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y
);

   // Operation select; shifts use the full b so callers decide on masking.
   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
         OP_SLL:  y = a << b;
         OP_SRL:  y = a >> b;
         OP_SRA:  y = $signed(a) >>> b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU.
// One request in flight: IDLE (accept) -> EXEC (compute) -> RESP (hold until taken).
// Build option ALU_ARB_RR_EN: round-robin on simultaneous requests;
// otherwise requester 0 always wins a tie.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_req0_valid,
   input  logic [DATA_W-1:0] i_req0_a,
   input  logic [DATA_W-1:0] i_req0_b,
   input  logic [3:0]        i_req0_op,
   output logic              o_req0_ready,
   input  logic              i_req1_valid,
   input  logic [DATA_W-1:0] i_req1_a,
   input  logic [DATA_W-1:0] i_req1_b,
   input  logic [3:0]        i_req1_op,
   output logic              o_req1_ready,
   output logic              o_rsp_valid,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rsp_id,
   input  logic              i_rsp_ready,
   output logic [15:0]       o_grant_cnt0,
   output logic [15:0]       o_grant_cnt1
);

   arb_state_e        state_q, state_d;
   logic              gnt0, gnt1;
   logic              acc0, acc1;
   logic [DATA_W-1:0] a_q, b_q, b_alu, alu_y;
   logic [3:0]        op_q;
   logic              id_q;
   logic [15:0]       cnt0_q, cnt1_q;

`ifdef ALU_ARB_RR_EN
   logic              last_grant_q;
`endif

   // Grant selection from the valids alone; a lone request always wins.
   always_comb begin
      gnt0 = i_req0_valid;
      gnt1 = i_req1_valid;
      if (i_req0_valid && i_req1_valid) begin
`ifdef ALU_ARB_RR_EN
         gnt0 = last_grant_q;
         gnt1 = !last_grant_q;
`else
         gnt0 = 1'b1;
         gnt1 = 1'b0;
`endif
      end
   end

   assign o_req0_ready = (state_q == ST_IDLE) && !i_reset && gnt0;
   assign o_req1_ready = (state_q == ST_IDLE) && !i_reset && gnt1;
   assign acc0         = o_req0_ready && i_req0_valid;
   assign acc1         = o_req1_ready && i_req1_valid;
   assign o_rsp_valid  = (state_q == ST_RESP);
   assign o_grant_cnt0 = cnt0_q;
   assign o_grant_cnt1 = cnt1_q;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (acc0 || acc1) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (i_rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift amounts are limited to 0..31 before reaching the ALU.
   assign b_alu = is_shift(op_q) ? {{(DATA_W-SHAMT_W){1'b0}}, b_q[SHAMT_W-1:0]} : b_q;

   alu #(.DATA_W(DATA_W)) u_alu (
      .op (op_q),
      .a  (a_q),
      .b  (b_alu),
      .y  (alu_y)
   );

   // Capture the granted request, then register the ALU result during EXEC.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         id_q       <= 1'b0;
         o_rsp_data <= '0;
         o_rsp_id   <= 1'b0;
      end else begin
         if (acc0 || acc1) begin
            a_q  <= acc1 ? i_req1_a  : i_req0_a;
            b_q  <= acc1 ? i_req1_b  : i_req0_b;
            op_q <= acc1 ? i_req1_op : i_req0_op;
            id_q <= acc1;
         end
         if (state_q == ST_EXEC) begin
            o_rsp_data <= alu_y;
            o_rsp_id   <= id_q;
         end
      end
   end

   // Saturating per-requester accept counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (acc0 && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
         if (acc1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
      end
   end

`ifdef ALU_ARB_RR_EN
   // Remember who won last so the next tie goes to the other requester.
   always_ff @(posedge i_clk) begin
      if (i_reset)           last_grant_q <= 1'b1;
      else if (acc0 || acc1) last_grant_q <= acc1;
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a stimulus/model process predicts grants,
// counters and responses; a separate monitor checks every presented result.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [3:0]  op0 = '0, op1 = '0;
   logic        r0, r1;
   logic        rsp_valid, rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_ready = 1'b1;
   logic [15:0] gc0, gc1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] data;
      logic        id;
      int          acc;
   } exp_t;
   exp_t q[$];

   // reference-model state
   int  cnt0_m = 0, cnt1_m = 0;
   bit  last_m = 1'b1;
   bit  busy_m = 1'b0;
   int  rsp_start_m = 0;
   bit  acc0_o = 1'b0, acc1_o = 1'b0;

   alu_arbiter #(.DATA_W(32)) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_req0_valid (v0),
      .i_req0_a     (a0),
      .i_req0_b     (b0),
      .i_req0_op    (op0),
      .o_req0_ready (r0),
      .i_req1_valid (v1),
      .i_req1_a     (a1),
      .i_req1_b     (b1),
      .i_req1_op    (op1),
      .o_req1_ready (r1),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_data   (rsp_data),
      .o_rsp_id     (rsp_id),
      .i_rsp_ready  (rsp_ready),
      .o_grant_cnt0 (gc0),
      .o_grant_cnt1 (gc1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Architectural result of one operation, straight from the op definitions.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6: return (a < b) ? 32'd1 : 32'd0;
         4'd7: return a << sh;
         4'd8: return a >> sh;
         4'd9: return $signed(a) >>> sh;
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit tie_to_0();
`ifdef ALU_ARB_RR_EN
      return last_m;
`else
      return 1'b1;
`endif
   endfunction

   // One clock: compare at negedge, update the model just after posedge.
   task automatic tick();
      bit idle, e0, e1, hs, in_rst;
      int nc;
      @(negedge clk);
      nc     = cyc;
      in_rst = rst;
      idle   = !busy_m && !in_rst;
      e0     = idle && v0 && (!v1 || tie_to_0());
      e1     = idle && v1 && !e0;
      chk("ready0", {31'd0, r0}, {31'd0, e0});
      chk("ready1", {31'd0, r1}, {31'd0, e1});
      chk("grant_cnt0", {16'd0, gc0}, cnt0_m);
      chk("grant_cnt1", {16'd0, gc1}, cnt1_m);
      hs = busy_m && (nc >= rsp_start_m) && rsp_ready;
      @(posedge clk);
      #1;
      if (in_rst) begin
         q.delete();
         cnt0_m = 0;
         cnt1_m = 0;
         last_m = 1'b1;
         busy_m = 1'b0;
         e0     = 1'b0;
         e1     = 1'b0;
      end else begin
         if (hs) busy_m = 1'b0;
         if (e0 || e1) begin
            exp_t x;
            x.data = e1 ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
            x.id   = e1;
            x.acc  = nc;
            q.push_back(x);
            busy_m      = 1'b1;
            rsp_start_m = nc + 2;
            last_m      = e1;
            if (e0 && cnt0_m != 65535) cnt0_m++;
            if (e1 && cnt1_m != 65535) cnt1_m++;
         end
      end
      acc0_o = e0;
      acc1_o = e1;
   endtask

   // Monitor: a result is due two cycles after accept and held until taken.
   always @(negedge clk) begin
      bit ev;
      ev = (q.size() > 0) && (cyc >= q[0].acc + 2);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ev});
      if (ev && rsp_valid) begin
         chk("rsp_data", rsp_data, q[0].data);
         chk("rsp_id", {31'd0, rsp_id}, {31'd0, q[0].id});
      end
      if (ev && rsp_ready) void'(q.pop_front());
   end

   task automatic wait_acc(input bit which, input string nm);
      for (int k = 0; k < 40; k++) begin
         tick();
         if (which ? acc1_o : acc0_o) return;
      end
      chk(nm, 32'd0, 32'd1);
   endtask

   task automatic drain();
      v0 = 1'b0;
      v1 = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      v0 = 1'b1;
      v1 = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      tick();

      // add from requester 0
      v0 = 1'b1; a0 = 32'd5; b0 = 32'd3; op0 = 4'b0000;
      wait_acc(1'b0, "acc_add");
      v0 = 1'b0;
      drain();

      // shift with amount masked from b
      v1 = 1'b1; a1 = 32'd1; b1 = 32'h0000_0024; op1 = 4'b0111;
      wait_acc(1'b1, "acc_sll");
      v1 = 1'b0;
      drain();

      // consumer stalls five cycles; a waiting requester must not be served early
      rsp_ready = 1'b0;
      v0 = 1'b1; a0 = 32'h8000_0010; b0 = 32'h0000_0041; op0 = 4'b1001;
      wait_acc(1'b0, "acc_stall");
      v0 = 1'b0;
      v1 = 1'b1; a1 = 32'd9; b1 = 32'd4; op1 = 4'b0001;
      for (int k = 0; k < 7; k++) tick();
      rsp_ready = 1'b1;
      wait_acc(1'b1, "acc_after_stall");
      v1 = 1'b0;
      drain();

      // both requesting continuously
      v0 = 1'b1; v1 = 1'b1;
      for (int k = 0; k < 24; k++) begin
         tick();
         if (acc0_o) begin a0 = $urandom; b0 = $urandom; op0 = 4'($urandom_range(0, 9)); end
         if (acc1_o) begin a1 = $urandom; b1 = $urandom; op1 = 4'($urandom_range(0, 9)); end
      end
      drain();

      // randomized traffic including unknown op codes and wide shift amounts
      for (int n = 0; n < 500; n++) begin
         if (!v0 || acc0_o) begin
            v0  = ($urandom_range(0, 3) != 0);
            a0  = $urandom;
            b0  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            op0 = 4'($urandom_range(0, 15));
         end
         if (!v1 || acc1_o) begin
            v1  = ($urandom_range(0, 3) != 0);
            a1  = $urandom;
            b1  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
            op1 = 4'($urandom_range(0, 15));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      // reset while a request is executing, then a tie
      v0 = 1'b1; a0 = 32'd7; b0 = 32'd8; op0 = 4'b0000;
      wait_acc(1'b0, "acc_pre_reset");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      v0 = 1'b1; v1 = 1'b1;
      tick();
      tick();
      drain();
      drain();

      // counter saturation
      force dut.cnt0_q = 16'hFFFE;
      #1;
      release dut.cnt0_q;
      cnt0_m = 16'hFFFE;
      for (int k = 0; k < 3; k++) begin
         v0 = 1'b1; a0 = 32'(k); b0 = 32'd1; op0 = 4'b0000;
         wait_acc(1'b0, "acc_sat");
         v0 = 1'b0;
         drain();
      end
      chk("cnt0_saturated", {16'd0, gc0}, 32'h0000_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand/result width (only 32 legal).
REQ-002 SHALL have port: i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: i_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: i_req0_valid / i_req1_valid  input  1  request present.
REQ-005 SHALL have ports: i_req0_a, i_req0_b / i_req1_a, i_req1_b  input  32  operands.
REQ-006 SHALL have ports: i_req0_op / i_req1_op  input  4  ALU op code (shared package encoding).
REQ-007 SHALL have ports: o_req0_ready / o_req1_ready  output  1  request accepted this cycle when valid&ready.
REQ-008 SHALL have ports: o_rsp_valid  output  1; o_rsp_data  output  32; o_rsp_id  output  1 (requester of result).
REQ-009 SHALL have port: i_rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports: o_grant_cnt0 / o_grant_cnt1  output  16  accepted-request counters.

Function
REQ-011 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other states.
REQ-012 In IDLE, SHALL assert ready only to the granted requester (combinational from valids); never both.
REQ-013 On valid&ready in IDLE, SHALL register a, b, op, id and move to EXEC.
REQ-014 In EXEC, SHALL drive the shared alu from registered operands and register result into o_rsp_data; move to RESP.
REQ-015 For op 0111/1000/1001 (SLL/SRL/SRA), SHALL zero-extend b[4:0] to 32 bits before the alu; other ops pass b unchanged.
REQ-016 In RESP, SHALL hold o_rsp_valid=1 with stable data/id until i_rsp_ready=1, then return to IDLE next cycle.
REQ-017 Latency: accept at cycle N -> o_rsp_valid at N+2; minimum 3 cycles between accepts.
REQ-018 Ready SHALL be 0 in EXEC and RESP; requesters hold valid and payload until accepted.
REQ-019 Unknown op codes SHALL be forwarded unmodified; result is whatever alu yields (0).
REQ-020 Single valid SHALL be granted immediately regardless of arbitration history.
REQ-021 o_grant_cntX SHALL increment on each accept of requester X and saturate at 16'hFFFF.

Reset
REQ-022 i_reset SHALL, at the next edge and from any state, force IDLE, o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, counters=0, last_grant=1.
REQ-023 A request accepted or result pending when reset asserts SHALL be discarded; readies SHALL be 0 while i_reset=1.

Configuration
REQ-024 With ALU_ARB_RR_EN defined, simultaneous valids SHALL be granted to the requester not in last_grant (round-robin); last_grant updates on every accept.
REQ-025 Without ALU_ARB_RR_EN, simultaneous valids SHALL always grant requester 0 (fixed priority); last_grant logic absent.

Structure
REQ-026 Shared package alu_pkg SHALL hold the 4-bit op code constants/enum and FSM state typedef.
REQ-027 SHALL instantiate the existing alu as its only sub-module; no duplicate arithmetic in this block.

Verification
REQ-028 req0 valid, a=5, b=3, op=0000, rsp_ready=1 -> o_rsp_valid at N+2, data=8, id=0, cnt0=1.
REQ-029 req1 op=0111, a=1, b=32'h0000_0024 -> data=32'h0000_0010 (shamt masked to 4).
REQ-030 Both valid continuously, RR_EN defined -> accepts alternate 0,1,0,1; without macro -> only 0 accepted.
REQ-031 rsp_ready=0 for 5 cycles in RESP -> valid/data/id stable, both readies 0; rsp_ready=1 -> IDLE next cycle.
REQ-032 Reset asserted during EXEC -> next cycle IDLE, o_rsp_valid=0, counters 0; post-reset tie grants req0.
REQ-033 Force cnt0 to 16'hFFFE, two req0 accepts -> cnt0=16'hFFFF, stays.
